// File: rtl/rst_sequencer_if.sv
// Status/reset bundle between the staged reset controller and its surroundings.
//   pll_locked_i, dcm_locked_i : clock generator lock indications (asynchronous)
//   ddr2_calib_i               : DDR2 calibration done (DDR2 clock domain)
//   sw_rst_req_i               : one-cycle software fabric/CPU reset request
//   ddr2_rst_o, wb_rst_o, cpu_rst_o : staged active-high resets
//   seq_state_o                : current sequencer state
//   calib_timeout_o, lock_lost_o    : sticky fault flags
interface rst_sequencer_if;
  logic       pll_locked_i;
  logic       dcm_locked_i;
  logic       ddr2_calib_i;
  logic       sw_rst_req_i;
  logic       ddr2_rst_o;
  logic       wb_rst_o;
  logic       cpu_rst_o;
  logic [2:0] seq_state_o;
  logic       calib_timeout_o;
  logic       lock_lost_o;

  // Controller side
  modport slave (
    input  pll_locked_i, dcm_locked_i, ddr2_calib_i, sw_rst_req_i,
    output ddr2_rst_o, wb_rst_o, cpu_rst_o, seq_state_o,
    output calib_timeout_o, lock_lost_o
  );

  // Clock generator / DDR2 / software side
  modport master (
    output pll_locked_i, dcm_locked_i, ddr2_calib_i, sw_rst_req_i,
    input  ddr2_rst_o, wb_rst_o, cpu_rst_o, seq_state_o,
    input  calib_timeout_o, lock_lost_o
  );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset controller: synchronises lock/calibration status into the
// Wishbone clock domain and releases DDR2 -> Wishbone -> CPU resets in order.
// Re-sequences on lock loss; supports a software fabric/CPU reset.
//   clk_i : Wishbone clock (wb_clk_o)
//   rst_i : asynchronous active-high reset (async_rst_o)
//   bus   : status inputs, staged reset outputs, state and sticky flags
module rst_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned LOCK_STABLE_CYC = 256,
  parameter int unsigned CALIB_TIMEOUT   = 1048576,
  parameter int unsigned RST_HOLD_CYC    = 16,
  parameter int unsigned CNT_W           = 21
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rst_sequencer_if.slave bus
);

  localparam logic [2:0] ST_RESET      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] ST_DDR_REL    = 3'd2;
  localparam logic [2:0] ST_WAIT_CALIB = 3'd3;
  localparam logic [2:0] ST_WB_REL     = 3'd4;
  localparam logic [2:0] ST_RUN        = 3'd5;
  localparam logic [2:0] ST_SW_RST     = 3'd6;
  localparam logic [2:0] ST_FAULT      = 3'd7;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYC - 1);

  logic [SYNC_STAGES-1:0] pll_sync_q;
  logic [SYNC_STAGES-1:0] dcm_sync_q;
  logic [SYNC_STAGES-1:0] calib_sync_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             timeout_q, timeout_d;
  logic             lost_q, lost_d;
  logic             ddr2_rst_q, ddr2_rst_d;
  logic             wb_rst_q, wb_rst_d;
  logic             cpu_rst_q, cpu_rst_d;

  logic lock_ok;
  logic calib_ok;
  logic lock_watch;

  // Multi-flop synchronisers, cleared by rst_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pll_sync_q   <= '0;
      dcm_sync_q   <= '0;
      calib_sync_q <= '0;
    end else begin
      pll_sync_q   <= {pll_sync_q[SYNC_STAGES-2:0], bus.pll_locked_i};
      dcm_sync_q   <= {dcm_sync_q[SYNC_STAGES-2:0], bus.dcm_locked_i};
      calib_sync_q <= {calib_sync_q[SYNC_STAGES-2:0], bus.ddr2_calib_i};
    end
  end

  assign lock_ok  = pll_sync_q[SYNC_STAGES-1] & dcm_sync_q[SYNC_STAGES-1];
  assign calib_ok = calib_sync_q[SYNC_STAGES-1];

  // Saturating increment: the counter parks at all-ones instead of wrapping
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // States in which a dropped lock forces a full re-sequence
  assign lock_watch = (state_q == ST_DDR_REL) || (state_q == ST_WAIT_CALIB) ||
                      (state_q == ST_WB_REL)  || (state_q == ST_RUN) ||
                      (state_q == ST_SW_RST);

  // State, counter and flag registers; reset outputs follow the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      lost_q     <= 1'b0;
      ddr2_rst_q <= 1'b1;
      wb_rst_q   <= 1'b1;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      lost_q     <= lost_d;
      ddr2_rst_q <= ddr2_rst_d;
      wb_rst_q   <= wb_rst_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Next-state, counter and reset-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    lost_d     = lost_q;
    ddr2_rst_d = 1'b1;
    wb_rst_d   = 1'b1;
    cpu_rst_d  = 1'b1;

    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      ST_WAIT_LOCK: begin
        if (!lock_ok) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_DDR_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DDR_REL: begin
        state_d = ST_WAIT_CALIB;
        cnt_d   = '0;
      end
      ST_WAIT_CALIB: begin
        // Calibration completing on the timeout edge still counts as success
        if (calib_ok) begin
          state_d = ST_WB_REL;
          cnt_d   = '0;
        end else if (cnt_q == CALIB_LAST) begin
          state_d   = ST_FAULT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB_REL: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        if (bus.sw_rst_req_i) begin
          state_d = ST_SW_RST;
          cnt_d   = '0;
        end
      end
      ST_SW_RST: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WB_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides every other transition
    if (lock_watch && !lock_ok) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      lost_d  = 1'b1;
    end

    case (state_d)
      ST_DDR_REL, ST_WAIT_CALIB, ST_SW_RST: begin
        ddr2_rst_d = 1'b0;
      end
      ST_WB_REL: begin
        ddr2_rst_d = 1'b0;
        wb_rst_d   = 1'b0;
      end
      ST_RUN: begin
        ddr2_rst_d = 1'b0;
        wb_rst_d   = 1'b0;
        cpu_rst_d  = 1'b0;
      end
      default: begin
        ddr2_rst_d = 1'b1;
      end
    endcase
  end

  assign bus.ddr2_rst_o      = ddr2_rst_q;
  assign bus.wb_rst_o        = wb_rst_q;
  assign bus.cpu_rst_o       = cpu_rst_q;
  assign bus.seq_state_o     = state_q;
  assign bus.calib_timeout_o = timeout_q;
  assign bus.lock_lost_o     = lost_q;

endmodule
